// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: req/ack data-memory handshake with lane placement and load extension.
// Optional misaligned-access trap is enabled by defining LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] store_data,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] load_data,
    output logic             misalign_err,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ack
);

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] addr_q;
    logic [2:0]       f3_q;
    logic             we_q;
    logic [WIDTH-1:0] wdata_q;
    logic [3:0]       wstrb_q;
    logic [WIDTH-1:0] load_data_q;

    logic             start;
    logic             is_byte, is_half;
    logic [1:0]       off;
    logic [WIDTH-1:0] lane_wdata;
    logic [3:0]       lane_wstrb;
    logic             mis;
    logic [7:0]       rd_byte;
    logic [15:0]      rd_half;
    logic [WIDTH-1:0] rd_ext;

    assign start   = (state_q == StIdle) && valid && (mem_read || mem_write);
    assign off     = addr[1:0];
    assign is_byte = (funct3 == 3'b000) || (funct3 == 3'b100);
    assign is_half = (funct3 == 3'b001) || (funct3 == 3'b101);

    // Store lane placement; unlisted codes behave as a full word.
    always_comb begin
        lane_wdata = store_data;
        lane_wstrb = 4'b1111;
        if (is_byte) begin
            lane_wdata = {4{store_data[7:0]}};
            lane_wstrb = 4'b0001 << off;
        end else if (is_half) begin
            lane_wdata = {2{store_data[15:0]}};
            lane_wstrb = 4'b0011 << {off[1], 1'b0};
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign_q;
    assign mis          = (is_half && off[0]) || (!is_byte && !is_half && (off != 2'b00));
    assign misalign_err = (state_q == StDone) && misalign_q;
`else
    assign mis          = 1'b0;
    assign misalign_err = 1'b0;
`endif

    // Load extraction from the latched offset and size.
    always_comb begin
        rd_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        rd_half = mem_rdata[{addr_q[1], 4'b0000} +: 16];
        rd_ext  = mem_rdata;
        case (f3_q)
            3'b000:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  rd_ext = {24'd0, rd_byte};
            3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
            3'b101:  rd_ext = {16'd0, rd_half};
            default: rd_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = mis ? StDone : StReq;
            StReq:   if (mem_ack) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            f3_q        <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            load_data_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (start) begin
                addr_q  <= addr;
                f3_q    <= funct3;
                we_q    <= mem_write;
                wdata_q <= lane_wdata;
                wstrb_q <= mem_write ? lane_wstrb : 4'b0000;
`ifdef LSU_MISALIGN_TRAP_EN
                misalign_q <= mis;
`endif
            end
            if ((state_q == StReq) && mem_ack && !we_q) begin
                load_data_q <= rd_ext;
            end
        end
    end

    assign stall     = start || (state_q == StReq);
    assign done      = (state_q == StDone);
    assign mem_req   = (state_q == StReq);
    assign mem_we    = mem_req && we_q;
    assign mem_wstrb = mem_req ? wstrb_q : 4'b0000;
    assign mem_addr  = {addr_q[WIDTH-1:2], 2'b00};
    assign mem_wdata = wdata_q;
    assign load_data = load_data_q;

endmodule
